// File: rtl/img_pkg.sv
// Shared image-geometry defaults, controller state encoding and width helpers.
package img_pkg;

    localparam int unsigned IMG_WIDTH_DEF  = 640;
    localparam int unsigned IMG_HEIGHT_DEF = 480;
    localparam int unsigned WIN_DEF        = 5;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned COL_W_DEF = cnt_width(IMG_WIDTH_DEF);
    localparam int unsigned ROW_W_DEF = cnt_width(IMG_HEIGHT_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/window_controller_raster_counter.sv
// Column/row raster counter. col/row hold the position of the last counted
// pixel; col_nxt/row_nxt give the position the next increment would reach,
// and the wrap flags say whether that next position is the last column/row.
module raster_counter
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned HEIGHT = IMG_HEIGHT_DEF,
    localparam int unsigned CW = cnt_width(WIDTH),
    localparam int unsigned RW = cnt_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col_nxt,
    output logic [RW-1:0] row_nxt,
    output logic          col_wrap,
    output logic          row_wrap
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last, row_last;

    // Incremented position with column wrap carrying into the row.
    always_comb begin
        col_last = (col_q == CW'(WIDTH - 1));
        row_last = (row_q == RW'(HEIGHT - 1));
        col_nxt  = col_last ? '0 : col_q + CW'(1);
        if (col_last) row_nxt = row_last ? '0 : row_q + RW'(1);
        else          row_nxt = row_q;
        col_wrap = (col_nxt == CW'(WIDTH - 1));
        row_wrap = (row_nxt == RW'(HEIGHT - 1));
    end

    // Clear has priority over increment; otherwise hold.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            col_d = col_nxt;
            row_d = row_nxt;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/window_controller.sv
// 5x5 sliding-window controller: tracks raster position of accepted pixels,
// drives the external row shift registers / line buffers and flags when the
// window ending at the current pixel is fully populated.
module window_controller
    import img_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int unsigned WIN        = WIN_DEF,
    localparam int unsigned CW = cnt_width(IMG_WIDTH),
    localparam int unsigned RW = cnt_width(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    input  logic          out_stall,
    output logic          shift_en,
    output logic [CW-1:0] lb_addr,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          win_valid,
    output logic          frame_done,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          accept, take;
    logic [CW-1:0] col_nxt, pix_col;
    logic [RW-1:0] row_nxt, pix_row;
    logic          col_wrap, row_wrap;
    logic          win_hit, last_hit, first_full;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_raster (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (take & ~in_sof),
        .clr      (accept & in_sof),
        .col      (col),
        .row      (row),
        .col_nxt  (col_nxt),
        .row_nxt  (row_nxt),
        .col_wrap (col_wrap),
        .row_wrap (row_wrap)
    );

    // Handshake outputs derived from state.
    always_comb begin
        in_ready = (state_q != ST_DONE) & ~out_stall;
        busy     = (state_q == ST_PRIME) | (state_q == ST_RUN);
    end

    // Position of the pixel being accepted this cycle; an in_sof pixel is (0,0).
    // In IDLE only an in_sof pixel is taken into the window pipeline.
    always_comb begin
        accept     = in_valid & in_ready;
        take       = accept & (in_sof | busy);
        pix_col    = in_sof ? '0 : col_nxt;
        pix_row    = in_sof ? '0 : row_nxt;
        win_hit    = (pix_row >= RW'(WIN - 1)) & (pix_col >= CW'(WIN - 1));
        first_full = (pix_row == RW'(WIN - 1)) & (pix_col == CW'(WIN - 1));
        last_hit   = ~in_sof & col_wrap & row_wrap;
        shift_en   = take;
        lb_addr    = pix_col;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && in_sof) state_d = ST_PRIME;
            ST_PRIME,
            ST_RUN: begin
                if (accept) begin
                    if (in_sof)                                state_d = ST_PRIME;
                    else if (last_hit)                         state_d = ST_DONE;
                    else if (state_q == ST_PRIME && first_full) state_d = ST_RUN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Window-valid and frame-done: follow the taken pixel, hold under stall,
    // drop on idle cycles and during DONE.
    always_comb begin
        win_valid_d  = 1'b0;
        frame_done_d = take & last_hit;
        if (state_q != ST_DONE) begin
            if (take)            win_valid_d = win_hit;
            else if (accept)     win_valid_d = 1'b0;
            else if (out_stall)  win_valid_d = win_valid_q;
        end
    end

    // State and registered flag updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_controller.sv
// Self-checking bench for window_controller at 8x6 geometry: a frame-index
// model is compared against the DUT every cycle, plus hand-computed checks.
module tb_window_controller;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sof, out_stall;
    logic       in_ready, shift_en, win_valid, frame_done, busy;
    logic [2:0] lb_addr, col, row;

    int pass_cnt = 0;
    int total    = 0;
    int wv_cnt   = 0;
    int fd_cnt   = 0;
    int rdy_lo_cnt = 0;

    window_controller #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .WIN        (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_stall  (out_stall),
        .shift_en   (shift_en),
        .lb_addr    (lb_addr),
        .col        (col),
        .row        (row),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: frame mode (0 idle, 1 in frame, 2 done) and index of last accepted pixel.
    int m_idx;
    int m_mode;
    bit m_wv, m_fd;
    bit e_rdy, e_acc, e_take;
    int e_nidx;

    always_comb begin
        e_rdy  = (m_mode != 2) && !out_stall;
        e_acc  = in_valid && e_rdy;
        e_take = e_acc && (in_sof || m_mode == 1);
        e_nidx = in_sof ? 0 : m_idx + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx  <= 0;
            m_mode <= 0;
            m_wv   <= 1'b0;
            m_fd   <= 1'b0;
        end else if (m_mode == 2) begin
            m_mode <= 0;
            m_wv   <= 1'b0;
            m_fd   <= 1'b0;
        end else if (e_take) begin
            m_idx  <= e_nidx;
            m_wv   <= (e_nidx / W >= 4) && (e_nidx % W >= 4);
            m_fd   <= !in_sof && (e_nidx == NPIX - 1);
            m_mode <= (!in_sof && (e_nidx == NPIX - 1)) ? 2 : 1;
        end else if (e_acc) begin
            m_wv <= 1'b0;
            m_fd <= 1'b0;
        end else begin
            m_fd <= 1'b0;
            if (!out_stall) m_wv <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",   int'(in_ready),   int'(e_rdy));
        chk("shift_en",   int'(shift_en),   int'(e_take));
        if (e_take) chk("lb_addr", int'(lb_addr), e_nidx % W);
        chk("col",        int'(col),        m_idx % W);
        chk("row",        int'(row),        m_idx / W);
        chk("win_valid",  int'(win_valid),  int'(m_wv));
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("busy",       int'(busy),       (m_mode == 1) ? 1 : 0);
        if (win_valid)  wv_cnt++;
        if (frame_done) fd_cnt++;
        if (!in_ready)  rdy_lo_cnt++;
    end

    task automatic cyc(input bit v, input bit s, input bit st);
        in_valid  = v;
        in_sof    = s;
        out_stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        wv_cnt = 0;
        fd_cnt = 0;
        rdy_lo_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_stall = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_col_row", int'({col, row}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pixels before any in_sof are discarded.
        repeat (3) begin
            cyc(1, 0, 0);
            chk("idle_shift_en", int'(shift_en), 0);
            chk("idle_busy", int'(busy), 0);
        end

        // Continuous frame.
        clr_cnt();
        for (int p = 0; p < NPIX; p++) begin
            cyc(1, p == 0, 0);
            if (p == 35) chk("wv_before_first", int'(win_valid), 0);
            if (p == 36) chk("wv_first", int'(win_valid), 1);
            if (p == 39) chk("wv_row4_col7", int'(win_valid), 1);
            if (p == 40) chk("wv_after_wrap", int'(win_valid), 0);
            if (p == NPIX - 1) begin
                chk("fd_last", int'(frame_done), 1);
                chk("done_ready", int'(in_ready), 0);
            end
        end
        cyc(0, 0, 0);
        chk("fd_pulse_end", int'(frame_done), 0);
        chk("idle_after_done", int'(busy), 0);
        chk("cont_wv_cnt", wv_cnt, 8);
        chk("cont_fd_cnt", fd_cnt, 1);

        // Stall mid-row at (4,6).
        clr_cnt();
        for (int p = 0; p <= 38; p++) cyc(1, p == 0, 0);
        repeat (3) begin
            cyc(1, 0, 1);
            chk("stall_ready", int'(in_ready), 0);
            chk("stall_col", int'(col), 6);
            chk("stall_row", int'(row), 4);
            chk("stall_wv", int'(win_valid), 1);
        end
        for (int p = 39; p < NPIX; p++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("stall_wv_cnt", wv_cnt, 11);
        chk("stall_fd_cnt", fd_cnt, 1);

        // Abort at (2,5) by a new in_sof.
        clr_cnt();
        for (int p = 0; p <= 21; p++) cyc(1, p == 0, 0);
        chk("pre_abort_col", int'(col), 5);
        cyc(1, 1, 0);
        chk("abort_col", int'(col), 0);
        chk("abort_row", int'(row), 0);
        chk("abort_busy", int'(busy), 1);
        cyc(0, 0, 0);
        chk("abort_no_fd", fd_cnt, 0);
        for (int p = 1; p < NPIX; p++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("abort_fd_cnt", fd_cnt, 1);
        chk("abort_wv_cnt", wv_cnt, 8);

        // Reset mid-frame at (4,6).
        for (int p = 0; p <= 38; p++) cyc(1, p == 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wv", int'(win_valid), 0);
        chk("mid_rst_col_row", int'({col, row}), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_fd", int'(frame_done), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin
            cyc(1, 0, 0);
            chk("post_rst_shift_en", int'(shift_en), 0);
        end

        // Gapped input: one idle cycle after each pixel.
        clr_cnt();
        for (int p = 0; p < NPIX; p++) begin
            cyc(1, p == 0, 0);
            cyc(0, 0, 0);
        end
        chk("gap_wv_cnt", wv_cnt, 8);
        chk("gap_fd_cnt", fd_cnt, 1);

        // Two back-to-back frames.
        clr_cnt();
        for (int p = 0; p < NPIX; p++) cyc(1, p == 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("f2_col", int'(col), 0);
        chk("f2_row", int'(row), 0);
        for (int p = 1; p < NPIX; p++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("b2b_ready_low", rdy_lo_cnt, 2);
        chk("b2b_fd_cnt", fd_cnt, 2);
        chk("b2b_wv_cnt", wv_cnt, 16);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/window_controller.md
WINDOW_CONTROLLER -- requirements
Module: window_controller

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (≥5).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (≥5).
REQ-003 Parameter WIN, default 5, window edge in pixels; fixed to 5 in this revision.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream pixel present.
REQ-007 in_sof  input  1  qualifies the current in_valid pixel as frame pixel (0,0).
REQ-008 in_ready  output  1  controller accepts a pixel this cycle.
REQ-009 out_stall  input  1  downstream cannot take a window this cycle.
REQ-010 shift_en  output  1  enable to all five row shift registers and line-buffer write.
REQ-011 lb_addr  output  clog2(IMG_WIDTH)  line-buffer column address for the accepted pixel.
REQ-012 col  output  clog2(IMG_WIDTH)  column of the last accepted pixel.
REQ-013 row  output  clog2(IMG_HEIGHT)  row of the last accepted pixel.
REQ-014 win_valid  output  1  the 5x5 window ending at (row,col) is fully populated.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-016 busy  output  1  high in PRIME or RUN.

Function
REQ-017 Accept = in_valid & in_ready; shift_en = accept (combinational, same cycle); lb_addr = column of the pixel being accepted (combinational).
REQ-018 in_ready = (state != DONE) & !out_stall.
REQ-019 States IDLE, PRIME, RUN, DONE; encoding from the shared package.
REQ-020 IDLE: in_ready high; pixels without in_sof are accepted and discarded (shift_en low); accept with in_sof -> PRIME, col=0, row=0.
REQ-021 Counters: col increments per accepted pixel; at IMG_WIDTH-1 wraps to 0 and row increments; no other updates.
REQ-022 PRIME -> RUN on the accept that sets row=WIN-1, col=WIN-1 (window first full).
REQ-023 win_valid registered: asserted the cycle after an accept whose (row,col) has row≥WIN-1 and col≥WIN-1; low otherwise, including the cycle after the wrap to col=0..3.
REQ-024 Accept at (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE; frame_done pulses for exactly the next cycle, together with the final win_valid.
REQ-025 DONE lasts one cycle (in_ready low), then -> IDLE.
REQ-026 in_sof on an accept in PRIME or RUN: abort current frame, no frame_done, treat pixel as (0,0), enter PRIME.
REQ-027 out_stall high: in_ready low, no accept, counters, state and win_valid hold.
REQ-028 in_valid low: no accept; counters hold; win_valid drops the next cycle.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, col=0, row=0, win_valid=0, frame_done=0; busy=0 follows.
REQ-030 rst_n asserted mid-frame discards the frame; the next frame must begin with in_sof.
REQ-031 Deassertion is synchronised externally; first accept possible on the first edge after release.

Structure
REQ-032 Shared package img_pkg holds IMG_WIDTH, IMG_HEIGHT, WIN defaults, the state enum and counter-width constants.
REQ-033 One sub-module raster_counter (col/row counter with enable, sync clear-to-zero, wrap flags) instantiated once.
REQ-034 The five 8-bit x5 row shift registers and line buffers sit outside this block, driven by shift_en/lb_addr.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-035 Continuous 48 valid pixels, first with in_sof -> win_valid first high the cycle after pixel 36 (row4,col4); 8 win_valid cycles total; frame_done once, after pixel 48.
REQ-036 out_stall high 3 cycles mid-row -> in_ready low 3 cycles, col/row frozen, win_valid value held.
REQ-037 in_sof at row2,col5 -> counters restart at (0,0), state PRIME, no frame_done for aborted frame.
REQ-038 rst_n low at row4,col6 for 1 cycle -> all outputs zero immediately; pixels without in_sof give shift_en=0.
REQ-039 Gaps (in_valid toggling every other cycle) -> identical col/row sequence and win_valid count to REQ-035.
REQ-040 Two back-to-back frames -> DONE costs one in_ready-low cycle; second frame counts restart at (0,0).
